// File: rtl/i2c_target_regfile.sv
// I2C target with a NUM_REGS x 8-bit register file, shared with a local fabric port.
// Open-drain: only output enables are driven; the pads are resolved outside this block.
module i2c_target_regfile #(
   parameter logic [6:0]  DEV_ADDR = 7'h3C,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       busy,
   output logic       wr_strobe,
   output logic [7:0] wr_index,
   input  logic [7:0] loc_addr,
   input  logic       loc_we,
   input  logic [7:0] loc_wdata,
   output logic [7:0] loc_rdata
);

   localparam int unsigned PW = $clog2(NUM_REGS);
   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam logic [FW-1:0] FLIM = FW'(FILT_LEN - 1);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAckA, StPtr, StAckP, StWr, StAckW, StRd, StRdAck, StIgnore, StWaitStop
   } state_e;

   logic [1:0]    sda_sync, scl_sync;
   logic          sda_f, scl_f, sda_p, scl_p;
   logic [FW-1:0] sda_cnt, scl_cnt;
   logic          scl_rise, scl_fall, start_c, stop_c;

   state_e        state;
   logic [7:0]    regs [NUM_REGS];
   logic [PW-1:0] ptr, ptr_inc, loc_idx;
   logic [7:0]    shreg, sh_next, tx, wr_data;
   logic [3:0]    bit_cnt;
   logic          rw;
   logic          unused_bits;

   assign scl_oe      = 1'b0;
   assign ptr_inc     = ptr + 1'b1;
   assign loc_idx     = loc_addr[PW-1:0];
   assign sh_next     = {shreg[6:0], sda_f};
   assign unused_bits = ^loc_addr;

   // A level is accepted only after FILT_LEN consecutive synchronised samples disagree with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sda_sync <= 2'b11;
         scl_sync <= 2'b11;
         sda_f    <= 1'b1;
         scl_f    <= 1'b1;
         sda_p    <= 1'b1;
         scl_p    <= 1'b1;
         sda_cnt  <= '0;
         scl_cnt  <= '0;
      end else begin
         sda_sync <= {sda_sync[0], sda_in};
         scl_sync <= {scl_sync[0], scl_in};
         sda_p    <= sda_f;
         scl_p    <= scl_f;
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FLIM) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FLIM) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
      end
   end

   assign scl_rise = scl_f & ~scl_p;
   assign scl_fall = ~scl_f & scl_p;
   assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
         wr_data   <= '0;
         loc_rdata <= '0;
         ptr       <= '0;
         shreg     <= '0;
         tx        <= '0;
         bit_cnt   <= '0;
         rw        <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         // I2C commit lands in the strobe cycle; a local write to the same index overrides it.
         if (wr_strobe) regs[wr_index[PW-1:0]] <= wr_data;
         if (loc_we) regs[loc_idx] <= loc_wdata;
         loc_rdata <= regs[loc_idx];

         if (stop_c) begin
            state   <= StIdle;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
         end else if (start_c) begin
            state   <= StAddr;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
         end else begin
            if (scl_rise) begin
               shreg   <= sh_next;
               bit_cnt <= bit_cnt + 1'b1;
            end
            unique case (state)
               StAddr: if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt <= '0;
                  rw      <= shreg[0];
                  if (shreg[7:1] == DEV_ADDR) begin
                     state  <= StAckA;
                     sda_oe <= 1'b1;
                     busy   <= 1'b1;
                  end else begin
                     state <= StIgnore;
                     busy  <= 1'b0;
                  end
               end
               StAckA: if (scl_fall) begin
                  bit_cnt <= '0;
                  if (rw) begin
                     state  <= StRd;
                     tx     <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                  end else begin
                     state  <= StPtr;
                     sda_oe <= 1'b0;
                  end
               end
               StPtr: if (scl_fall && bit_cnt == 4'd8) begin
                  ptr    <= shreg[PW-1:0];
                  sda_oe <= 1'b1;
                  state  <= StAckP;
               end
               StAckP: if (scl_fall) begin
                  sda_oe  <= 1'b0;
                  bit_cnt <= '0;
                  state   <= StWr;
               end
               StWr: begin
                  if (scl_rise && bit_cnt == 4'd7) begin
                     wr_strobe <= 1'b1;
                     wr_index  <= 8'(ptr);
                     wr_data   <= sh_next;
                  end
                  if (scl_fall && bit_cnt == 4'd8) begin
                     sda_oe <= 1'b1;
                     state  <= StAckW;
                  end
               end
               StAckW: if (scl_fall) begin
                  sda_oe  <= 1'b0;
                  bit_cnt <= '0;
                  ptr     <= ptr_inc;
                  state   <= StWr;
               end
               StRd: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= StRdAck;
                  end else begin
                     tx     <= {tx[6:0], 1'b0};
                     sda_oe <= ~tx[6];
                  end
               end
               StRdAck: begin
                  if (scl_rise && sda_f) begin
                     state <= StWaitStop;
                     busy  <= 1'b0;
                  end else if (scl_fall) begin
                     ptr     <= ptr_inc;
                     tx      <= regs[ptr_inc];
                     sda_oe  <= ~regs[ptr_inc][7];
                     bit_cnt <= '0;
                     state   <= StRd;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bench acts as the I2C initiator; a scoreboard
// queue holds expected ACK/read bytes and wr_strobe indices, popped by a monitor process.
module tb_i2c_target_regfile;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sda_m = 1'b1, scl_m = 1'b1, glitch = 1'b0;
   logic       sda_oe, scl_oe, busy, wr_strobe;
   logic [7:0] wr_index, loc_rdata;
   logic [7:0] loc_addr = '0, loc_wdata = '0;
   logic       loc_we = 1'b0;
   logic       sda_line, sda_in, scl_in;

   assign sda_line = sda_m & ~sda_oe;
   assign sda_in   = sda_line ^ glitch;
   assign scl_in   = scl_m & ~scl_oe;

   always #5 clk = ~clk;

   i2c_target_regfile dut (
      .clk       (clk),
      .reset     (reset),
      .sda_in    (sda_in),
      .scl_in    (scl_in),
      .sda_oe    (sda_oe),
      .scl_oe    (scl_oe),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .loc_addr  (loc_addr),
      .loc_we    (loc_we),
      .loc_wdata (loc_wdata),
      .loc_rdata (loc_rdata)
   );

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_rx[$];
   string      exp_rx_name[$];
   logic [7:0] exp_wr[$];
   logic       rx_valid = 1'b0;
   logic [7:0] rx_val = '0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_strobe) begin
         if (exp_wr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_strobe: unexpected pulse, index 0x%02h, expected none", wr_index);
         end else begin
            chk("wr_index", wr_index, exp_wr.pop_front());
         end
      end
      if (rx_valid) begin
         if (exp_rx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx: unexpected value 0x%02h, expected none", rx_val);
         end else begin
            chk(exp_rx_name.pop_front(), rx_val, exp_rx.pop_front());
         end
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [7:0] v);
      rx_val   = v;
      rx_valid = 1'b1;
      wclk(1);
      rx_valid = 1'b0;
   endtask

   task automatic bit_xfer(input logic b, input logic gl, input logic col, output logic r);
      logic seen;
      wclk(Q);
      sda_m = b;
      wclk(Q);
      scl_m = 1'b1;
      if (gl) begin
         wclk(Q / 2);
         glitch = 1'b1;
         wclk(1);
         glitch = 1'b0;
      end
      if (col) begin
         seen = 1'b0;
         for (int i = 0; i < 15 && !seen; i++) begin
            wclk(1);
            if (wr_strobe) seen = 1'b1;
         end
         chk("t6_strobe_seen", {7'd0, seen}, 8'd1);
         loc_addr  = 8'd3;
         loc_wdata = 8'h77;
         loc_we    = seen;
         wclk(1);
         loc_we = 1'b0;
         wclk(1);
         chk("t6_loc_rdata_next", loc_rdata, 8'h77);
      end
      wclk(Q);
      r = sda_line;
      wclk(Q);
      scl_m = 1'b0;
   endtask

   task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_ack,
                          input logic [7:0] gmask, input logic col);
      logic r;
      exp_rx.push_back({7'd0, exp_ack});
      exp_rx_name.push_back(name);
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], gmask[i], col && (i == 0), r);
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      present({7'd0, r});
   endtask

   task automatic rd_byte(input string name, input logic [7:0] exp, input logic ack);
      logic       r;
      logic [7:0] d;
      exp_rx.push_back(exp);
      exp_rx_name.push_back(name);
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, 1'b0, 1'b0, r);
         d[i] = r;
      end
      present(d);
      bit_xfer(ack, 1'b0, 1'b0, r);
   endtask

   task automatic start_c();
      sda_m = 1'b0;
      wclk(2 * Q);
      scl_m = 1'b0;
   endtask

   task automatic rstart_c();
      wclk(Q);
      sda_m = 1'b1;
      wclk(Q);
      scl_m = 1'b1;
      wclk(2 * Q);
      sda_m = 1'b0;
      wclk(2 * Q);
      scl_m = 1'b0;
   endtask

   task automatic stop_c();
      wclk(Q);
      sda_m = 1'b0;
      wclk(Q);
      scl_m = 1'b1;
      wclk(2 * Q);
      sda_m = 1'b1;
      wclk(2 * Q);
   endtask

   task automatic loc_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
      loc_addr = a;
      wclk(2);
      chk(name, loc_rdata, exp);
   endtask

   task automatic loc_wr(input logic [7:0] a, input logic [7:0] d);
      loc_addr  = a;
      loc_wdata = d;
      loc_we    = 1'b1;
      wclk(1);
      loc_we = 1'b0;
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   initial begin
      #900000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
      summary();
      $finish;
   end

   initial begin
      logic r;
      wclk(5);
      chk("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
      chk("rst_scl_oe", {7'd0, scl_oe}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_wr_strobe", {7'd0, wr_strobe}, 8'd0);
      chk("rst_wr_index", wr_index, 8'd0);
      chk("rst_loc_rdata", loc_rdata, 8'd0);
      reset = 1'b0;
      wclk(5);

      // 1: pointer 5, two data bytes
      start_c();
      wr_byte("t1_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      chk("t1_busy", {7'd0, busy}, 8'd1);
      wr_byte("t1_ptr_ack", 8'h05, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd5);
      wr_byte("t1_d0_ack", 8'hA5, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd6);
      wr_byte("t1_d1_ack", 8'h5A, 1'b0, 8'h00, 1'b0);
      stop_c();
      chk("t1_busy_after", {7'd0, busy}, 8'd0);
      loc_rd("t1_reg5", 8'd5, 8'hA5);
      loc_rd("t1_reg6", 8'd6, 8'h5A);

      // 2: set pointer 15, repeated START, read with wrap
      loc_wr(8'd15, 8'hC3);
      loc_wr(8'd0, 8'h81);
      start_c();
      wr_byte("t2_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t2_ptr_ack", 8'h0F, 1'b0, 8'h00, 1'b0);
      rstart_c();
      wr_byte("t2_raddr_ack", 8'h79, 1'b0, 8'h00, 1'b0);
      rd_byte("t2_rd_reg15", 8'hC3, 1'b0);
      rd_byte("t2_rd_reg0", 8'h81, 1'b1);
      chk("t2_busy_nack", {7'd0, busy}, 8'd0);
      stop_c();

      // 3: wrong address, then a good transaction
      start_c();
      wr_byte("t3_nack", 8'h7A, 1'b1, 8'h00, 1'b0);
      chk("t3_busy", {7'd0, busy}, 8'd0);
      chk("t3_sda_oe", {7'd0, sda_oe}, 8'd0);
      stop_c();
      loc_rd("t3_reg5_kept", 8'd5, 8'hA5);
      start_c();
      wr_byte("t3_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t3_ptr_ack", 8'h07, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd7);
      wr_byte("t3_d_ack", 8'h3E, 1'b0, 8'h00, 1'b0);
      stop_c();
      loc_rd("t3_reg7", 8'd7, 8'h3E);

      // 4: STOP after half a data byte
      start_c();
      wr_byte("t4_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t4_ptr_ack", 8'h09, 1'b0, 8'h00, 1'b0);
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      bit_xfer(1'b0, 1'b0, 1'b0, r);
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      bit_xfer(1'b0, 1'b0, 1'b0, r);
      stop_c();
      chk("t4_sda_oe", {7'd0, sda_oe}, 8'd0);
      chk("t4_busy", {7'd0, busy}, 8'd0);
      loc_rd("t4_reg9", 8'd9, 8'h00);

      // 5: single-cycle SDA glitches while SCL high
      start_c();
      wr_byte("t5_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t5_ptr_ack", 8'h0A, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd10);
      wr_byte("t5_d_ack", 8'h96, 1'b0, 8'hC0, 1'b0);
      stop_c();
      loc_rd("t5_reg10", 8'd10, 8'h96);

      // 6: local write collides with I2C commit to reg3
      start_c();
      wr_byte("t6_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t6_ptr_ack", 8'h03, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd3);
      wr_byte("t6_d_ack", 8'h11, 1'b0, 8'h00, 1'b1);
      stop_c();
      loc_rd("t6_reg3", 8'd3, 8'h77);

      // 7: reset while the target is driving the address ACK
      start_c();
      for (int i = 7; i >= 0; i--) bit_xfer(i == 0 ? 1'b0 : (8'h78 >> i) & 8'h01, 1'b0, 1'b0, r);
      wclk(Q);
      chk("t7_ack_driven", {7'd0, sda_oe}, 8'd1);
      reset = 1'b1;
      wclk(1);
      chk("t7_sda_oe_rst", {7'd0, sda_oe}, 8'd0);
      chk("t7_busy_rst", {7'd0, busy}, 8'd0);
      reset = 1'b0;
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      stop_c();
      loc_rd("t7_reg5_cleared", 8'd5, 8'h00);
      start_c();
      wr_byte("t7_addr_ack", 8'h78, 1'b0, 8'h00, 1'b0);
      wr_byte("t7_ptr_ack", 8'h01, 1'b0, 8'h00, 1'b0);
      exp_wr.push_back(8'd1);
      wr_byte("t7_d_ack", 8'h42, 1'b0, 8'h00, 1'b0);
      stop_c();
      loc_rd("t7_reg1", 8'd1, 8'h42);

      wclk(20);
      while (exp_rx.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no response seen, expected 0x%02h", exp_rx_name.pop_front(),
                  exp_rx.pop_front());
      end
      while (exp_wr.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wr_strobe_missing: no pulse observed, expected index 0x%02h",
                  exp_wr.pop_front());
      end
      summary();
      $finish;
   end

endmodule
